// File: rtl/cuda_core_pkg.sv
// Purpose : shared types and constants for the CUDA core writeback path.
// Latency : n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   REG_ADDR_W / REG_DATA_W : register-file address and data widths
//   wb_entry_t              : one queued writeback {addr, data}
//   wb_src_e                : writeback source (integer ALU or FPU)
//   wb_rr_pick()            : round-robin winner given the last granted source
package cuda_core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_INT = 1'b0,
    WB_SRC_FP  = 1'b1
  } wb_src_e;

  // On a tie the source that did not win last time gets the port.
  function automatic wb_src_e wb_rr_pick(input wb_src_e last_grant);
    return (last_grant == WB_SRC_FP) ? WB_SRC_INT : WB_SRC_FP;
  endfunction

endpackage

// File: rtl/cuda_wb_fifo.sv
// Purpose : small per-source writeback queue (one instance per result channel).
// Latency : a push at edge N is visible on head/empty in the following cycle.
// Backpressure: full is raised at DEPTH entries; pushes while full are ignored,
//               so a pop cannot make room for a push in the same cycle.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset (empties the queue)
//   push, push_entry  : enqueue request and payload
//   pop               : dequeue the head entry (ignored when empty)
//   head              : current head entry (valid while !empty)
//   full, empty       : occupancy flags
module cuda_wb_fifo
  import cuda_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic push_ok;
  logic pop_ok;

  // Explicit wrap so the pointer stays in range for any DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/cuda_writeback_arb.sv
// Purpose : merges integer-ALU and FPU results onto the single register-file write port.
// Latency : 2 cycles uncontended (transfer in cycle t -> write_en in cycle t+2).
// Backpressure: per-channel ready = queue not full (and low during reset); one pop per cycle.
//
// Optional feature: define CUDA_WB_PERF_CNT_EN to add the performance counter
// outputs int_wr_cnt, fp_wr_cnt and conflict_cnt.
//
// Ports:
//   clk, rst                                 : clock, synchronous active-high reset
//   int_valid/int_ready/int_addr/int_data    : integer-ALU result channel
//   fp_valid/fp_ready/fp_addr/fp_data        : FPU result channel
//   write_en/write_addr/write_data           : register-file write port (registered)
//   write_is_float                           : 1 when the write came from the FPU
//   busy                                     : any queued entry or a write in flight
//   int_wr_cnt/fp_wr_cnt/conflict_cnt        : perf counters (CUDA_WB_PERF_CNT_EN only)
module cuda_writeback_arb
  import cuda_core_pkg::*;
#(
  parameter int FIFO_DEPTH = 2  // legal: 2, 4, 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  int_valid,
  output logic                  int_ready,
  input  logic [REG_ADDR_W-1:0] int_addr,
  input  logic [REG_DATA_W-1:0] int_data,

  input  logic                  fp_valid,
  output logic                  fp_ready,
  input  logic [REG_ADDR_W-1:0] fp_addr,
  input  logic [REG_DATA_W-1:0] fp_data,

  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [REG_DATA_W-1:0] write_data,
  output logic                  write_is_float,

  output logic                  busy
`ifdef CUDA_WB_PERF_CNT_EN
  ,
  output logic [31:0]           int_wr_cnt,
  output logic [31:0]           fp_wr_cnt,
  output logic [31:0]           conflict_cnt
`endif
);

  wb_entry_t int_head;
  wb_entry_t fp_head;
  wb_entry_t int_in;
  wb_entry_t fp_in;
  wb_entry_t pop_entry;

  logic    int_full;
  logic    int_empty;
  logic    fp_full;
  logic    fp_empty;
  logic    int_push;
  logic    fp_push;
  logic    int_pop;
  logic    fp_pop;
  logic    pop_any;
  logic    both_pending;
  wb_src_e grant_src;
  wb_src_e last_grant;

  // Ready is held low while reset is asserted so nothing is accepted into a
  // queue that is being cleared on the same edge.
  assign int_ready = ~int_full & ~rst;
  assign fp_ready  = ~fp_full & ~rst;
  assign int_push  = int_valid & int_ready;
  assign fp_push   = fp_valid & fp_ready;

  assign int_in = '{addr: int_addr, data: int_data};
  assign fp_in  = '{addr: fp_addr, data: fp_data};

  cuda_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_int_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (int_push),
    .push_entry (int_in),
    .pop        (int_pop),
    .head       (int_head),
    .full       (int_full),
    .empty      (int_empty)
  );

  cuda_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fp_push),
    .push_entry (fp_in),
    .pop        (fp_pop),
    .head       (fp_head),
    .full       (fp_full),
    .empty      (fp_empty)
  );

  assign both_pending = ~int_empty & ~fp_empty;

  // Grant selection: round-robin on a tie, otherwise whichever queue has data.
  always_comb begin
    grant_src = last_grant;
    pop_any   = 1'b0;
    if (both_pending) begin
      grant_src = wb_rr_pick(last_grant);
      pop_any   = 1'b1;
    end else if (!int_empty) begin
      grant_src = WB_SRC_INT;
      pop_any   = 1'b1;
    end else if (!fp_empty) begin
      grant_src = WB_SRC_FP;
      pop_any   = 1'b1;
    end
  end

  assign int_pop   = pop_any & (grant_src == WB_SRC_INT);
  assign fp_pop    = pop_any & (grant_src == WB_SRC_FP);
  assign pop_entry = (grant_src == WB_SRC_FP) ? fp_head : int_head;

  // Output stage. Writes to r0 are consumed from the queue but never strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en       <= 1'b0;
      write_addr     <= '0;
      write_data     <= '0;
      write_is_float <= 1'b0;
      last_grant     <= WB_SRC_FP;
    end else begin
      write_en <= pop_any & (pop_entry.addr != '0);
      if (pop_any) begin
        write_addr     <= pop_entry.addr;
        write_data     <= pop_entry.data;
        write_is_float <= (grant_src == WB_SRC_FP);
        last_grant     <= grant_src;
      end
    end
  end

  assign busy = ~int_empty | ~fp_empty | write_en;

`ifdef CUDA_WB_PERF_CNT_EN
  // Counted on the edge that launches the write, so each count matches one
  // write_en pulse of that source.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_wr_cnt   <= '0;
      fp_wr_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (int_pop && (pop_entry.addr != '0)) begin
        int_wr_cnt <= int_wr_cnt + 32'd1;
      end
      if (fp_pop && (pop_entry.addr != '0)) begin
        fp_wr_cnt <= fp_wr_cnt + 32'd1;
      end
      if (both_pending) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
